// File: rtl/equiv_miter_checker_if.sv
// Bundle between an equivalence miter and its driver/monitor: the shared stimulus
// valid, both design outputs, clear, and the checker's verdict/debug outputs.
interface equiv_miter_checker_if #(
    parameter int WIDTH = 91,
    parameter int CNT_W = 16,
    parameter int IDX_W = 32
);
    logic             valid_in;
    logic [WIDTH-1:0] y_a;
    logic [WIDTH-1:0] y_b;
    logic             clear;
    logic             mismatch;
    logic             fail;
    logic [1:0]       state;
    logic [CNT_W-1:0] mismatch_count;
    logic [IDX_W-1:0] sample_idx;
    logic [IDX_W-1:0] first_idx;
    logic [WIDTH-1:0] first_xor;

    modport master (
        output valid_in, y_a, y_b, clear,
        input  mismatch, fail, state, mismatch_count, sample_idx, first_idx, first_xor
    );

    modport slave (
        input  valid_in, y_a, y_b, clear,
        output mismatch, fail, state, mismatch_count, sample_idx, first_idx, first_xor
    );
endinterface

// File: rtl/equiv_miter_checker.sv
// Two-design equivalence miter: latency-aligns y_a/y_b, masks a warm-up window,
// then flags, counts and captures the first divergence between the two streams.
module equiv_miter_checker #(
    parameter int WIDTH  = 91,
    parameter int LAT_A  = 0,
    parameter int LAT_B  = 0,
    parameter int WARMUP = 4,
    parameter int CNT_W  = 16,
    parameter int IDX_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    equiv_miter_checker_if.slave bus
);
    localparam int LMAX = (LAT_A > LAT_B) ? LAT_A : LAT_B;
    localparam int DA   = LMAX - LAT_A;
    localparam int DB   = LMAX - LAT_B;
    localparam int DV   = LMAX;

    localparam logic [1:0] ST_WARMUP = 2'b00;
    localparam logic [1:0] ST_CHECK  = 2'b01;
    localparam logic [1:0] ST_FAIL   = 2'b10;
    localparam logic [1:0] ST_INIT   = (WARMUP == 0) ? ST_CHECK : ST_WARMUP;
    localparam logic [7:0] WARM_INIT = 8'(WARMUP);

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [IDX_W-1:0] sat_inc_idx(input logic [IDX_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [WIDTH-1:0] a_al_p0;
    logic [WIDTH-1:0] b_al_p0;
    logic             vld_p0;
    logic             diff_p0;
    logic             chk_p0;
    logic             hit_p0;

    logic             mismatch_p1;
    logic             fail_p1;
    logic [1:0]       state_p1;
    logic [CNT_W-1:0] cnt_p1;
    logic [IDX_W-1:0] idx_p1;
    logic [IDX_W-1:0] first_idx_p1;
    logic [WIDTH-1:0] first_xor_p1;
    logic [7:0]       warm_cnt;

    // Alignment stage: pad the faster side so both streams line up with valid_in.
    generate
        if (DA == 0) begin : g_a_pass
            assign a_al_p0 = bus.y_a;
        end else begin : g_a_dly
            logic [WIDTH-1:0] sr [DA];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DA; i++) sr[i] <= '0;
                end else begin
                    sr[0] <= bus.y_a;
                    for (int i = 1; i < DA; i++) sr[i] <= sr[i-1];
                end
            end
            assign a_al_p0 = sr[DA-1];
        end

        if (DB == 0) begin : g_b_pass
            assign b_al_p0 = bus.y_b;
        end else begin : g_b_dly
            logic [WIDTH-1:0] sr [DB];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DB; i++) sr[i] <= '0;
                end else begin
                    sr[0] <= bus.y_b;
                    for (int i = 1; i < DB; i++) sr[i] <= sr[i-1];
                end
            end
            assign b_al_p0 = sr[DB-1];
        end

        if (DV == 0) begin : g_v_pass
            assign vld_p0 = bus.valid_in;
        end else begin : g_v_dly
            logic sr [DV];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DV; i++) sr[i] <= 1'b0;
                end else begin
                    sr[0] <= bus.valid_in;
                    for (int i = 1; i < DV; i++) sr[i] <= sr[i-1];
                end
            end
            assign vld_p0 = sr[DV-1];
        end
    endgenerate

    // An unknown compare result falls through to the mismatch branch.
    always_comb begin
        diff_p0 = 1'b1;
        if (a_al_p0 == b_al_p0) diff_p0 = 1'b0;
    end

    assign chk_p0 = vld_p0 && (state_p1 != ST_WARMUP);
    assign hit_p0 = chk_p0 && diff_p0;

    // Result stage: verdict, counters and first-failure capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch_p1  <= 1'b0;
            fail_p1      <= 1'b0;
            state_p1     <= ST_INIT;
            cnt_p1       <= '0;
            idx_p1       <= '0;
            first_idx_p1 <= '0;
            first_xor_p1 <= '0;
            warm_cnt     <= WARM_INIT;
        end else if (bus.clear) begin
            mismatch_p1  <= 1'b0;
            fail_p1      <= 1'b0;
            state_p1     <= ST_INIT;
            cnt_p1       <= '0;
            idx_p1       <= '0;
            first_idx_p1 <= '0;
            first_xor_p1 <= '0;
            warm_cnt     <= WARM_INIT;
        end else begin
            mismatch_p1 <= hit_p0;
            if (chk_p0) idx_p1 <= sat_inc_idx(idx_p1);
            if (hit_p0) cnt_p1 <= sat_inc_cnt(cnt_p1);

            case (state_p1)
                ST_WARMUP: begin
                    if (vld_p0) begin
                        warm_cnt <= warm_cnt - 8'd1;
                        if (warm_cnt <= 8'd1) state_p1 <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (hit_p0) begin
                        fail_p1      <= 1'b1;
                        first_idx_p1 <= idx_p1;
                        first_xor_p1 <= a_al_p0 ^ b_al_p0;
                        state_p1     <= ST_FAIL;
                    end
                end
                ST_FAIL: begin
                    state_p1 <= ST_FAIL;
                end
                default: begin
                    state_p1 <= ST_INIT;
                end
            endcase
        end
    end

    assign bus.mismatch       = mismatch_p1;
    assign bus.fail           = fail_p1;
    assign bus.state          = state_p1;
    assign bus.mismatch_count = cnt_p1;
    assign bus.sample_idx     = idx_p1;
    assign bus.first_idx      = first_idx_p1;
    assign bus.first_xor      = first_xor_p1;
endmodule

// File: tb/tb_equiv_miter_checker.sv
// Directed bench for equiv_miter_checker: five configurations exercised in one
// linear sequence with hand-computed expectations.
module tb_equiv_miter_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    equiv_miter_checker_if #(.WIDTH(91), .CNT_W(16), .IDX_W(32)) i0 ();
    equiv_miter_checker_if #(.WIDTH(91), .CNT_W(16), .IDX_W(32)) i1 ();
    equiv_miter_checker_if #(.WIDTH(91), .CNT_W(16), .IDX_W(32)) i2 ();
    equiv_miter_checker_if #(.WIDTH(16), .CNT_W(16), .IDX_W(32)) i3 ();
    equiv_miter_checker_if #(.WIDTH(8),  .CNT_W(4),  .IDX_W(4))  i4 ();

    equiv_miter_checker #(.WIDTH(91), .LAT_A(0), .LAT_B(0), .WARMUP(0), .CNT_W(16), .IDX_W(32))
        u0 (.clk(clk), .rst(rst), .bus(i0.slave));
    equiv_miter_checker #(.WIDTH(91), .LAT_A(3), .LAT_B(1), .WARMUP(0), .CNT_W(16), .IDX_W(32))
        u1 (.clk(clk), .rst(rst), .bus(i1.slave));
    equiv_miter_checker #(.WIDTH(91), .LAT_A(3), .LAT_B(2), .WARMUP(0), .CNT_W(16), .IDX_W(32))
        u2 (.clk(clk), .rst(rst), .bus(i2.slave));
    equiv_miter_checker #(.WIDTH(16), .LAT_A(0), .LAT_B(0), .WARMUP(4), .CNT_W(16), .IDX_W(32))
        u3 (.clk(clk), .rst(rst), .bus(i3.slave));
    equiv_miter_checker #(.WIDTH(8),  .LAT_A(0), .LAT_B(0), .WARMUP(0), .CNT_W(4),  .IDX_W(4))
        u4 (.clk(clk), .rst(rst), .bus(i4.slave));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stimulus-derived output of the shared function; zero before the stream starts.
    function automatic logic [90:0] sval(input int c);
        return (c < 0) ? 91'd0 : 91'(c + 1);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [95:0] r;
        logic [90:0] ya;
        logic [90:0] b90;
        logic [4:0]  vpat;
        b90  = 91'd1 << 90;
        vpat = 5'b01101;

        i0.valid_in = 0; i0.y_a = '0; i0.y_b = '0; i0.clear = 0;
        i1.valid_in = 0; i1.y_a = '0; i1.y_b = '0; i1.clear = 0;
        i2.valid_in = 0; i2.y_a = '0; i2.y_b = '0; i2.clear = 0;
        i3.valid_in = 0; i3.y_a = '0; i3.y_b = '0; i3.clear = 0;
        i4.valid_in = 0; i4.y_a = '0; i4.y_b = '0; i4.clear = 0;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_u0_mismatch", 128'(i0.mismatch), 128'(1'b0));
        chk("rst_u0_fail",     128'(i0.fail), 128'(1'b0));
        chk("rst_u0_state",    128'(i0.state), 128'(2'b01));
        chk("rst_u0_count",    128'(i0.mismatch_count), 128'(0));
        chk("rst_u0_idx",      128'(i0.sample_idx), 128'(0));
        chk("rst_u3_state",    128'(i3.state), 128'(2'b00));

        // 100 identical random samples
        for (int k = 0; k < 100; k++) begin
            r = {$urandom(), $urandom(), $urandom()};
            i0.valid_in = 1'b1; i0.y_a = r[90:0]; i0.y_b = r[90:0];
            @(negedge clk);
            chk("eq_mismatch", 128'(i0.mismatch), 128'(1'b0));
        end
        i0.valid_in = 1'b0;
        chk("eq_idx",   128'(i0.sample_idx), 128'(100));
        chk("eq_count", 128'(i0.mismatch_count), 128'(0));
        chk("eq_fail",  128'(i0.fail), 128'(1'b0));
        chk("eq_state", 128'(i0.state), 128'(2'b01));

        i0.clear = 1'b1;
        @(negedge clk);
        i0.clear = 1'b0;
        chk("clr_idx",   128'(i0.sample_idx), 128'(0));
        chk("clr_state", 128'(i0.state), 128'(2'b01));

        // bit 90 flipped on sample 37, bit 0 on sample 40
        for (int k = 0; k < 42; k++) begin
            r = {$urandom(), $urandom(), $urandom()};
            ya = r[90:0];
            i0.valid_in = 1'b1; i0.y_a = ya;
            i0.y_b = ya ^ ((k == 37) ? b90 : 91'd0) ^ ((k == 40) ? 91'd1 : 91'd0);
            @(negedge clk);
            chk($sformatf("flip_mismatch_%0d", k), 128'(i0.mismatch), 128'((k == 37) || (k == 40)));
        end
        i0.valid_in = 1'b0;
        chk("flip_fail",      128'(i0.fail), 128'(1'b1));
        chk("flip_state",     128'(i0.state), 128'(2'b10));
        chk("flip_first_idx", 128'(i0.first_idx), 128'(37));
        chk("flip_first_xor", 128'(i0.first_xor), 128'(b90));
        chk("flip_count",     128'(i0.mismatch_count), 128'(2));
        chk("flip_idx",       128'(i0.sample_idx), 128'(42));

        // A lags by 3, B by 1; gapped valid pattern 1,0,1,1,0
        for (int c = 0; c < 24; c++) begin
            i1.valid_in = (c < 20) && vpat[c % 5];
            i2.valid_in = i1.valid_in;
            i1.y_a = sval(c - 3); i1.y_b = sval(c - 1);
            i2.y_a = sval(c - 3); i2.y_b = sval(c - 1);
            @(negedge clk);
            chk($sformatf("lat_ok_mismatch_%0d", c), 128'(i1.mismatch), 128'(1'b0));
        end
        i1.valid_in = 1'b0; i2.valid_in = 1'b0;
        chk("lat_ok_idx",       128'(i1.sample_idx), 128'(12));
        chk("lat_ok_count",     128'(i1.mismatch_count), 128'(0));
        chk("lat_ok_fail",      128'(i1.fail), 128'(1'b0));
        chk("lat_ok_state",     128'(i1.state), 128'(2'b01));
        chk("lat_bad_fail",     128'(i2.fail), 128'(1'b1));
        chk("lat_bad_state",    128'(i2.state), 128'(2'b10));
        chk("lat_bad_count",    128'(i2.mismatch_count), 128'(12));
        chk("lat_bad_first_ix", 128'(i2.first_idx), 128'(0));
        chk("lat_bad_first_x",  128'(i2.first_xor), 128'(3));

        // WARMUP=4: first four samples differ but are masked
        for (int k = 0; k < 10; k++) begin
            i3.valid_in = 1'b1; i3.y_a = 16'(k); i3.y_b = (k < 4) ? ~16'(k) : 16'(k);
            @(negedge clk);
            chk($sformatf("warm_mismatch_%0d", k), 128'(i3.mismatch), 128'(1'b0));
            if (k == 2) chk("warm_state_k2", 128'(i3.state), 128'(2'b00));
            if (k == 3) chk("warm_state_k3", 128'(i3.state), 128'(2'b01));
            if (k == 3) chk("warm_idx_k3",   128'(i3.sample_idx), 128'(0));
        end
        i3.y_a = 16'h00F0; i3.y_b = 16'h00FF;
        @(negedge clk);
        chk("warm_late_mismatch", 128'(i3.mismatch), 128'(1'b1));
        i3.valid_in = 1'b0;
        chk("warm_fail",      128'(i3.fail), 128'(1'b1));
        chk("warm_first_idx", 128'(i3.first_idx), 128'(6));
        chk("warm_first_xor", 128'(i3.first_xor), 128'(16'h000F));
        chk("warm_idx",       128'(i3.sample_idx), 128'(7));

        i3.clear = 1'b1;
        @(negedge clk);
        i3.clear = 1'b0;
        chk("warm_clr_state", 128'(i3.state), 128'(2'b00));
        chk("warm_clr_fail",  128'(i3.fail), 128'(1'b0));
        chk("warm_clr_xor",   128'(i3.first_xor), 128'(0));
        for (int k = 0; k < 4; k++) begin
            i3.valid_in = 1'b1; i3.y_a = 16'h1234; i3.y_b = 16'h4321;
            @(negedge clk);
        end
        i3.valid_in = 1'b0;
        chk("warm_rearm_fail",  128'(i3.fail), 128'(1'b0));
        chk("warm_rearm_state", 128'(i3.state), 128'(2'b01));
        chk("warm_rearm_count", 128'(i3.mismatch_count), 128'(0));

        // Saturation with 4-bit counters
        for (int k = 0; k < 20; k++) begin
            i4.valid_in = 1'b1; i4.y_a = 8'(k); i4.y_b = 8'(k) ^ 8'h5A;
            @(negedge clk);
        end
        i4.valid_in = 1'b0;
        chk("sat_count",     128'(i4.mismatch_count), 128'(15));
        chk("sat_idx",       128'(i4.sample_idx), 128'(15));
        chk("sat_first_idx", 128'(i4.first_idx), 128'(0));
        chk("sat_first_xor", 128'(i4.first_xor), 128'(8'h5A));
        chk("sat_state",     128'(i4.state), 128'(2'b10));

        // Asynchronous reset mid-stream with samples in flight in u2
        for (int k = 0; k < 2; k++) begin
            i2.valid_in = 1'b1; i2.y_a = 91'd1; i2.y_b = 91'd2;
            @(negedge clk);
        end
        i2.valid_in = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_u0_fail",  128'(i0.fail), 128'(1'b0));
        chk("arst_u0_state", 128'(i0.state), 128'(2'b01));
        chk("arst_u0_count", 128'(i0.mismatch_count), 128'(0));
        chk("arst_u0_idx",   128'(i0.sample_idx), 128'(0));
        chk("arst_u0_fidx",  128'(i0.first_idx), 128'(0));
        chk("arst_u0_fxor",  128'(i0.first_xor), 128'(0));
        chk("arst_u2_fail",  128'(i2.fail), 128'(1'b0));
        chk("arst_u4_count", 128'(i4.mismatch_count), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("arst_u2_flush_count", 128'(i2.mismatch_count), 128'(0));
        chk("arst_u2_flush_fail",  128'(i2.fail), 128'(1'b0));
        chk("arst_u2_flush_idx",   128'(i2.sample_idx), 128'(0));

        // clear coincident with a differing sample
        i0.valid_in = 1'b1; i0.y_a = 91'd5; i0.y_b = 91'd6; i0.clear = 1'b1;
        @(negedge clk);
        i0.clear = 1'b0; i0.valid_in = 1'b0;
        chk("clrhit_mismatch", 128'(i0.mismatch), 128'(1'b0));
        chk("clrhit_count",    128'(i0.mismatch_count), 128'(0));
        chk("clrhit_fail",     128'(i0.fail), 128'(1'b0));
        chk("clrhit_idx",      128'(i0.sample_idx), 128'(0));
        i0.valid_in = 1'b1;
        @(negedge clk);
        i0.valid_in = 1'b0;
        chk("clrhit_after_count", 128'(i0.mismatch_count), 128'(1));
        chk("clrhit_after_xor",   128'(i0.first_xor), 128'(3));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
